// File: rtl/spi_axis_pkg.sv
// Shared definitions for the SPI master with AXI-Stream byte interfaces.
// Contents: FSM state type, byte and bit-count widths, and bit-order helpers
// used by the TX and RX shift registers.
package spi_axis_pkg;

    localparam int BYTE_W     = 8;
    localparam int BIT_CNT_W  = 3;               // indexes the 8 bits of a byte
    localparam int EDGE_CNT_W = BIT_CNT_W + 1;   // counts the 16 SCLK edges of a byte

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_STORE  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // Bit that leaves the TX register next.
    function automatic logic out_bit(input logic [BYTE_W-1:0] data, input logic msb_first);
        return msb_first ? data[BYTE_W-1] : data[0];
    endfunction

    // TX register after its outgoing bit has been consumed.
    function automatic logic [BYTE_W-1:0] shift_out(input logic [BYTE_W-1:0] data, input logic msb_first);
        return msb_first ? {data[BYTE_W-2:0], 1'b0} : {1'b0, data[BYTE_W-1:1]};
    endfunction

    // RX register after one more received bit; the first bit received ends
    // up at bit 7 for MSB-first and at bit 0 for LSB-first.
    function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] data, input logic b,
                                                   input logic msb_first);
        return msb_first ? {data[BYTE_W-2:0], b} : {b, data[BYTE_W-1:1]};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator.
// Ports: clk_in/rst_in system clock and async active-high reset; en_in runs
// the clock; sclk_out is the registered SPI clock (CPOL while idle);
// lead_stb_out/trail_stb_out flag the cycle at whose end sclk_out makes its
// leading/trailing transition.
module spi_clk_gen #(
    parameter int CLK_DIV_G        = 2,
    parameter int CLOCK_POLARITY_G = 0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic en_in,
    output logic sclk_out,
    output logic lead_stb_out,
    output logic trail_stb_out
);

    localparam int             CNT_W    = $clog2(CLK_DIV_G) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV_G - 1);
    localparam logic           CPOL     = (CLOCK_POLARITY_G != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             tick_s;

    // Half-period counter; disabling snaps SCLK back to its idle level.
    always_comb begin
        tick_s = 1'b0;
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (en_in) begin
            if (cnt_q == CNT_LAST) begin
                tick_s = 1'b1;
                cnt_d  = '0;
                sclk_d = ~sclk_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d  = '0;
            sclk_d = CPOL;
        end
    end

    // Counter and SCLK registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q  <= '0;
            sclk_q <= CPOL;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    // A transition away from the idle level is the leading edge.
    assign lead_stb_out  = tick_s & (sclk_q == CPOL);
    assign trail_stb_out = tick_s & (sclk_q != CPOL);
    assign sclk_out      = sclk_q;

endmodule

// File: rtl/spi_axis_master.sv
// SPI master moving one byte at a time between AXI-Stream and the SPI bus.
// Ports: clk_in/rst_in (async active-high); sclk/mosi/miso/cs SPI bus (cs
// active-low); s_axis_* TX bytes in, m_axis_* RX bytes out; trigger arms a
// transaction; busy marks an armed/active transaction; num_bytes counts the
// bytes completed in the current or last transaction.
module spi_axis_master
    import spi_axis_pkg::*;
#(
    parameter int CLOCK_POLARITY_G = 0,
    parameter int CLOCK_PHASE_G    = 0,
    parameter int MSB_FIRST_G      = 1,
    parameter int CLK_DIV_G        = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs,
    input  logic [BYTE_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [BYTE_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    input  logic              trigger,
    output logic [31:0]       num_bytes,
    output logic              busy
);

    localparam logic CPHA = (CLOCK_PHASE_G != 0);
    localparam logic MSBF = (MSB_FIRST_G != 0);
    localparam int   CNT_W = $clog2(CLK_DIV_G) + 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(CLK_DIV_G - 1);
    localparam logic [EDGE_CNT_W-1:0] EDGE_LAST = EDGE_CNT_W'(15);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [EDGE_CNT_W-1:0]   edge_q, edge_d;
    logic [BYTE_W-1:0]       tx_q, tx_d, rx_q, rx_d, m_tdata_q, m_tdata_d;
    logic                    tlast_lat_q, tlast_lat_d, mosi_q, mosi_d, cs_q, cs_d;
    logic                    s_tready_q, s_tready_d, m_tvalid_q, m_tvalid_d;
    logic                    m_tlast_q, m_tlast_d, busy_q, busy_d;
    logic [31:0]             num_q, num_d;
    logic                    clk_en_s, lead_s, trail_s, sample_s, drive_s, last_edge_s;

    assign clk_en_s    = (state_q == ST_SHIFT);
    assign sample_s    = CPHA ? trail_s : lead_s;
    assign drive_s     = CPHA ? lead_s  : trail_s;
    assign last_edge_s = (edge_q == EDGE_LAST);

    spi_clk_gen #(
        .CLK_DIV_G        (CLK_DIV_G),
        .CLOCK_POLARITY_G (CLOCK_POLARITY_G)
    ) u_clk_gen (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .en_in         (clk_en_s),
        .sclk_out      (sclk),
        .lead_stb_out  (lead_s),
        .trail_stb_out (trail_s)
    );

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        edge_d      = edge_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        tlast_lat_d = tlast_lat_q;
        mosi_d      = mosi_q;
        cs_d        = cs_q;
        s_tready_d  = s_tready_q;
        m_tvalid_d  = m_tvalid_q;
        m_tdata_d   = m_tdata_q;
        m_tlast_d   = m_tlast_q;
        num_d       = num_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    num_d      = 32'd0;
                    busy_d     = 1'b1;
                    s_tready_d = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (s_tready_q && s_axis_tvalid) begin
                    tlast_lat_d = s_axis_tlast;
                    cs_d        = 1'b0;
                    s_tready_d  = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_SETUP;
                    // CPHA=0 slaves sample on the first edge, so bit 0 must be
                    // on the wire before SCLK starts.
                    if (!CPHA) begin
                        mosi_d = out_bit(s_axis_tdata, MSBF);
                        tx_d   = shift_out(s_axis_tdata, MSBF);
                    end else begin
                        mosi_d = 1'b0;
                        tx_d   = s_axis_tdata;
                    end
                end else begin
                    s_tready_d = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    edge_d  = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (sample_s) begin
                    rx_d = shift_in(rx_q, miso, MSBF);
                end else begin
                    rx_d = rx_q;
                end
                // With CPHA=0 the final trailing edge has no bit left to drive.
                if (drive_s && !(!CPHA && last_edge_s)) begin
                    mosi_d = out_bit(tx_q, MSBF);
                    tx_d   = shift_out(tx_q, MSBF);
                end else begin
                    tx_d = tx_q;
                end
                if (lead_s || trail_s) begin
                    edge_d = edge_q + EDGE_CNT_W'(1);
                    if (last_edge_s) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = rx_d;
                        m_tlast_d  = tlast_lat_q;
                        state_d    = ST_STORE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    edge_d = edge_q;
                end
            end
            ST_STORE: begin
                if (m_tvalid_q && m_axis_tready) begin
                    m_tvalid_d = 1'b0;
                    m_tlast_d  = 1'b0;
                    num_d      = num_q + 32'd1;
                    cnt_d      = '0;
                    if (tlast_lat_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        s_tready_d = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end else begin
                    state_d = ST_STORE;
                end
            end
            ST_FINISH: begin
                if (cnt_q == CNT_LAST) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cs_d       = 1'b1;
                mosi_d     = 1'b0;
                s_tready_d = 1'b0;
                m_tvalid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            edge_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            tlast_lat_q <= 1'b0;
            mosi_q      <= 1'b0;
            cs_q        <= 1'b1;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tlast_q   <= 1'b0;
            num_q       <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            edge_q      <= edge_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            tlast_lat_q <= tlast_lat_d;
            mosi_q      <= mosi_d;
            cs_q        <= cs_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tdata_q   <= m_tdata_d;
            m_tlast_q   <= m_tlast_d;
            num_q       <= num_d;
            busy_q      <= busy_d;
        end
    end

    assign mosi          = mosi_q;
    assign cs            = cs_q;
    assign s_axis_tready = s_tready_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tlast  = m_tlast_q;
    assign num_bytes     = num_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_spi_axis_master.sv
// Bench for spi_axis_master. Instance 0 is mode 0 MSB-first; instances 1-3
// cover modes 1-3; instance 4 is mode 0 LSB-first. Each instance has an SPI
// slave model that returns a fixed byte stream and checks decoded MOSI bytes
// against a queue; a monitor checks every m_axis beat against a second queue.
module tb_spi_axis_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        trigger_a [5];
    logic        s_tvalid_a [5];
    logic        s_tlast_a [5];
    logic [7:0]  s_tdata_a [5];
    logic        m_tready_a [5];
    logic        sclk_a [5];
    logic        mosi_a [5];
    logic        cs_a [5];
    logic        s_tready_a [5];
    logic        m_tvalid_a [5];
    logic        m_tlast_a [5];
    logic [7:0]  m_tdata_a [5];
    logic        busy_a [5];
    logic [31:0] num_a [5];

    logic [7:0]  resp_tab [4] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    logic [7:0]  exp_mosi [$];
    logic [12:0] exp_m [$];     // {instance, tlast, data}

    int total = 0;
    int bad = 0;
    int inv_bad = 0;
    int cs_falls = 0;
    int sclk_rises = 0;
    int rises_at_fall = 0;
    int sclk_toggles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic cpol_of(input int i);
        return (i == 2 || i == 3);
    endfunction

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int CPOL_L = (g == 2 || g == 3) ? 1 : 0;
        localparam int CPHA_L = (g == 1 || g == 3) ? 1 : 0;
        localparam int MSBF_L = (g == 4) ? 0 : 1;
        logic miso_s;

        spi_axis_master #(
            .CLOCK_POLARITY_G (CPOL_L),
            .CLOCK_PHASE_G    (CPHA_L),
            .MSB_FIRST_G      (MSBF_L),
            .CLK_DIV_G        (2)
        ) u_dut (
            .clk_in        (clk),
            .rst_in        (rst),
            .sclk          (sclk_a[g]),
            .mosi          (mosi_a[g]),
            .miso          (miso_s),
            .cs            (cs_a[g]),
            .s_axis_tdata  (s_tdata_a[g]),
            .s_axis_tvalid (s_tvalid_a[g]),
            .s_axis_tready (s_tready_a[g]),
            .s_axis_tlast  (s_tlast_a[g]),
            .m_axis_tdata  (m_tdata_a[g]),
            .m_axis_tvalid (m_tvalid_a[g]),
            .m_axis_tready (m_tready_a[g]),
            .m_axis_tlast  (m_tlast_a[g]),
            .trigger       (trigger_a[g]),
            .num_bytes     (num_a[g]),
            .busy          (busy_a[g])
        );

        // Bit n of the slave's outgoing stream for one cs-low period.
        function automatic logic stream_bit(input int n);
            logic [7:0] b;
            b = resp_tab[(n / 8) % 4];
            return (MSBF_L != 0) ? b[7 - (n % 8)] : b[n % 8];
        endfunction

        // SPI slave model: drive/sample on SCLK edges according to the mode.
        initial begin : slave_bfm
            int drv_n;
            int smp_n;
            logic [7:0] cap;
            logic prev_cs;
            logic prev_sclk;
            logic lead;
            drv_n = 0; smp_n = 0; cap = 8'h00;
            prev_cs = 1'b1; prev_sclk = 1'(CPOL_L); miso_s = 1'b0;
            forever begin
                @(cs_a[g] or sclk_a[g]);
                if (cs_a[g] !== prev_cs) begin
                    drv_n = 0; smp_n = 0;
                    if (cs_a[g] === 1'b0 && CPHA_L == 0) begin
                        miso_s = stream_bit(0);
                        drv_n = 1;
                    end else begin
                        miso_s = 1'b0;
                    end
                end else if (cs_a[g] === 1'b0 && sclk_a[g] !== prev_sclk) begin
                    lead = (prev_sclk == 1'(CPOL_L));
                    if (lead == (CPHA_L == 0)) begin
                        cap = (MSBF_L != 0) ? {cap[6:0], mosi_a[g]} : {mosi_a[g], cap[7:1]};
                        smp_n++;
                        if (smp_n % 8 == 0) begin
                            if (exp_mosi.size() == 0) begin
                                total++; bad++;
                                $display("FAIL mosi_unexpected: got 0x%0h, want no byte", cap);
                            end else begin
                                check("mosi_byte", 32'(cap), 32'(exp_mosi.pop_front()));
                            end
                        end
                    end else begin
                        miso_s = stream_bit(drv_n);
                        drv_n++;
                    end
                end
                prev_cs = cs_a[g];
                prev_sclk = sclk_a[g];
            end
        end
    end

    // SCLK/cs activity counters for instance 0.
    always @(negedge cs_a[0]) begin
        cs_falls++;
        rises_at_fall = sclk_rises;
    end
    always @(posedge sclk_a[0]) if (cs_a[0] === 1'b0) sclk_rises++;
    always @(sclk_a[0]) sclk_toggles++;

    // m_axis monitor and protocol invariants, sampled mid-cycle.
    logic       hold_prev [5];
    logic [8:0] hold_val [5];
    always begin
        @(negedge clk);
        #2;
        for (int i = 0; i < 5; i++) begin
            if (rst !== 1'b0) begin
                hold_prev[i] = 1'b0;
            end else begin
                if (hold_prev[i] && (!m_tvalid_a[i] || {m_tlast_a[i], m_tdata_a[i]} != hold_val[i])) inv_bad++;
                if (!busy_a[i] && !cs_a[i]) inv_bad++;
                if (cs_a[i] && mosi_a[i]) inv_bad++;
                if (cs_a[i] && sclk_a[i] != cpol_of(i)) inv_bad++;
                if (s_tready_a[i] && m_tvalid_a[i]) inv_bad++;
                if (m_tvalid_a[i] && m_tready_a[i]) begin
                    if (exp_m.size() == 0) begin
                        total++; bad++;
                        $display("FAIL m_axis_unexpected: got inst %0d data 0x%0h, want no beat", i, m_tdata_a[i]);
                    end else begin
                        check("m_axis_beat", 32'({4'(i), m_tlast_a[i], m_tdata_a[i]}), 32'(exp_m.pop_front()));
                    end
                end
                hold_prev[i] = m_tvalid_a[i] && !m_tready_a[i];
                hold_val[i]  = {m_tlast_a[i], m_tdata_a[i]};
            end
        end
    end

    task automatic pulse_trigger(input int i);
        trigger_a[i] = 1'b1;
        @(negedge clk);
        trigger_a[i] = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge after the handshake.
    task automatic send_beat(input int i, input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_tdata_a[i] = d; s_tlast_a[i] = l; s_tvalid_a[i] = 1'b1;
        while (!s_tready_a[i] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("s_axis_accept_in_time", 32'(n < 2000), 32'd1);
        @(negedge clk);
        s_tvalid_a[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy_a[i] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("busy_falls_in_time", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        int n;
        int base_rises;
        int base_falls;
        int tog0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            trigger_a[i] = 1'b0; s_tvalid_a[i] = 1'b0; s_tlast_a[i] = 1'b0;
            s_tdata_a[i] = 8'h00; m_tready_a[i] = 1'b1; hold_prev[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("rst_cs", 32'(cs_a[i]), 32'd1);
            check("rst_sclk_idle", 32'(sclk_a[i]), 32'(cpol_of(i)));
        end
        check("rst_mosi", 32'(mosi_a[0]), 32'd0);
        check("rst_s_tready", 32'(s_tready_a[0]), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid_a[0]), 32'd0);
        check("rst_busy", 32'(busy_a[0]), 32'd0);
        check("rst_num_bytes", num_a[0], 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // tvalid without trigger must be ignored
        stray = 0;
        s_tvalid_a[0] = 1'b1; s_tdata_a[0] = 8'h11;
        repeat (10) begin
            @(negedge clk);
            if (s_tready_a[0] || !cs_a[0] || busy_a[0]) stray++;
        end
        s_tvalid_a[0] = 1'b0;
        check("no_trigger_no_accept", 32'(stray), 32'd0);

        // three-byte mode 0 transaction
        exp_mosi.push_back(8'h37); exp_mosi.push_back(8'h48); exp_mosi.push_back(8'h59);
        exp_m.push_back({4'd0, 1'b0, 8'hA5});
        exp_m.push_back({4'd0, 1'b0, 8'h5A});
        exp_m.push_back({4'd0, 1'b1, 8'hC3});
        base_rises = sclk_rises; base_falls = cs_falls;
        pulse_trigger(0);
        check("busy_after_trigger", 32'(busy_a[0]), 32'd1);
        send_beat(0, 8'h37, 1'b0);
        send_beat(0, 8'h48, 1'b0);
        send_beat(0, 8'h59, 1'b1);
        wait_idle(0);
        check("sclk_periods_3b", 32'(sclk_rises - base_rises), 32'd24);
        check("cs_falls_3b", 32'(cs_falls - base_falls), 32'd1);
        check("num_bytes_3b", num_a[0], 32'd3);
        check("cs_high_at_idle", 32'(cs_a[0]), 32'd1);

        // backpressure: m_axis_tready low for 50 cycles after first byte
        m_tready_a[0] = 1'b0;
        exp_mosi.push_back(8'h12); exp_mosi.push_back(8'h34);
        exp_m.push_back({4'd0, 1'b0, 8'hA5});
        exp_m.push_back({4'd0, 1'b1, 8'h5A});
        pulse_trigger(0);
        send_beat(0, 8'h12, 1'b0);
        n = 0;
        while (!m_tvalid_a[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("m_tvalid_in_time", 32'(n < 2000), 32'd1);
        tog0 = sclk_toggles;
        repeat (50) @(negedge clk);
        check("bp_sclk_frozen", 32'(sclk_toggles - tog0), 32'd0);
        check("bp_tvalid_held", 32'(m_tvalid_a[0]), 32'd1);
        check("bp_tdata_held", 32'(m_tdata_a[0]), 32'hA5);
        m_tready_a[0] = 1'b1;
        send_beat(0, 8'h34, 1'b1);
        wait_idle(0);
        check("num_bytes_bp", num_a[0], 32'd2);

        // reset during bit 4 of a byte
        pulse_trigger(0);
        send_beat(0, 8'h66, 1'b1);
        n = 0;
        while ((sclk_rises - rises_at_fall) < 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_bit4_in_time", 32'(n < 2000), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_sclk", 32'(sclk_a[0]), 32'd0);
        check("abort_mosi", 32'(mosi_a[0]), 32'd0);
        check("abort_cs", 32'(cs_a[0]), 32'd1);
        check("abort_s_tready", 32'(s_tready_a[0]), 32'd0);
        check("abort_m_tvalid", 32'(m_tvalid_a[0]), 32'd0);
        check("abort_m_tlast", 32'(m_tlast_a[0]), 32'd0);
        check("abort_m_tdata", 32'(m_tdata_a[0]), 32'd0);
        check("abort_busy", 32'(busy_a[0]), 32'd0);
        check("abort_num_bytes", num_a[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // transaction after the abort
        exp_mosi.push_back(8'h9C);
        exp_m.push_back({4'd0, 1'b1, 8'hA5});
        pulse_trigger(0);
        send_beat(0, 8'h9C, 1'b1);
        wait_idle(0);
        check("num_bytes_after_abort", num_a[0], 32'd1);

        // remaining SPI modes and LSB-first
        for (int i = 1; i < 5; i++) begin
            exp_mosi.push_back(8'h37);
            exp_m.push_back({4'(i), 1'b1, 8'hA5});
            pulse_trigger(i);
            send_beat(i, 8'h37, 1'b1);
            wait_idle(i);
            check("mode_sclk_idle", 32'(sclk_a[i]), 32'(cpol_of(i)));
            check("mode_num_bytes", num_a[i], 32'd1);
        end

        repeat (4) @(negedge clk);
        check("mosi_queue_drained", 32'(exp_mosi.size()), 32'd0);
        check("m_axis_queue_drained", 32'(exp_m.size()), 32'd0);
        check("protocol_invariants", 32'(inv_bad), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_axis_master.md
SPI_AXIS_MASTER -- requirements
Module: spi_axis_master

Interface
REQ-001 Parameter CLOCK_POLARITY_G, default 0: SCLK idle level (CPOL).
REQ-002 Parameter CLOCK_PHASE_G, default 0: 0 = sample on leading edge, drive on trailing; 1 = drive on leading, sample on trailing (CPHA).
REQ-003 Parameter MSB_FIRST_G, default 1: 1 = bit 7 shifted first; 0 = bit 0 first, on both MOSI and MISO.
REQ-004 Parameter CLK_DIV_G, default 2, minimum 1: clk_in cycles per SCLK half-period.
REQ-005 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_in  input  1  reset, asynchronous and active-high.
REQ-007 sclk  output  1  SPI clock; mosi  output  1  SPI data out; miso  input  1  SPI data in; cs  output  1  chip select, active-low.
REQ-008 s_axis_tdata  input  8  TX byte; s_axis_tvalid  input  1; s_axis_tready  output  1; s_axis_tlast  input  1  last byte of transaction.
REQ-009 m_axis_tdata  output  8  RX byte; m_axis_tvalid  output  1; m_axis_tready  input  1; m_axis_tlast  output  1.
REQ-010 trigger  input  1  arms one transaction; num_bytes  output  32  bytes completed in current/last transaction; busy  output  1  transaction armed or in progress.

Function
REQ-011 States SHALL be IDLE, FETCH, SETUP, SHIFT, STORE, FINISH.
REQ-012 IDLE: busy=0, cs=1, s_axis_tready=0; trigger=1 -> clear num_bytes, go FETCH next cycle; trigger ignored in any other state.
REQ-013 FETCH: busy=1, s_axis_tready=1; on tvalid&tready latch tdata and tlast into TX shift register and flag, drive cs=0, go SETUP; no beat -> wait indefinitely (cs keeps its value).
REQ-014 SETUP: hold CLK_DIV_G cycles with sclk=CPOL; for CPHA=0 first bit is presented on mosi on entry; then go SHIFT.
REQ-015 SHIFT: exactly 8 SCLK periods, 16 edges, each CLK_DIV_G cycles apart; MISO sampled on sample edge per REQ-002, MOSI updated on drive edge; sclk returns to CPOL after last edge, then STORE.
REQ-016 STORE: m_axis_tvalid=1, m_axis_tdata = received byte, m_axis_tlast = latched tlast; hold stable until m_axis_tready; on handshake num_bytes += 1; go FINISH if tlast else FETCH.
REQ-017 Backpressure: no SCLK activity while STORE waits; cs stays 0 across bytes of one transaction.
REQ-018 FINISH: hold cs=0 for CLK_DIV_G cycles, then cs=1, busy=0, IDLE; num_bytes holds final count until next trigger.
REQ-019 s_axis_tready SHALL be 1 only in FETCH; m_axis_tvalid only in STORE; at most one byte in flight.
REQ-020 mosi SHALL be 0 when cs=1; num_bytes wraps modulo 2^32.

Reset
REQ-021 rst_in=1 SHALL immediately force IDLE, sclk=CPOL, mosi=0, cs=1, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, num_bytes=0, clear shift registers, counters and armed state.
REQ-022 Reset mid-transfer SHALL abort without emitting a partial byte on m_axis.

Structure
REQ-023 Shared package spi_axis_pkg: state enum type, byte width constant 8, bit-count width.
REQ-024 One sub-module spi_clk_gen: half-period counter producing sclk and lead/trail edge strobes from CLK_DIV_G, CPOL.

Verification
REQ-025 Mode 0, CLK_DIV_G=2: trigger pulse, then beats 0x37, 0x48, 0x59(tlast) -> MOSI carries 0x37,0x48,0x59 MSB first, cs low once for 24 SCLKs, num_bytes=3, busy falls after cs rises.
REQ-026 Same stimulus, slave returns 0xA5,0x5A,0xC3 -> m_axis emits 0xA5,0x5A,0xC3, tlast only on 0xC3.
REQ-027 All four CPOL/CPHA modes and MSB_FIRST_G=0 with 0x37 -> slave BFM decodes 0x37; sclk idles at CPOL.
REQ-028 m_axis_tready held 0 for 50 cycles after first byte -> sclk frozen, m_axis data stable, transfer resumes, no loss.
REQ-029 s_axis_tvalid asserted without trigger -> s_axis_tready stays 0, cs stays 1.
REQ-030 rst_in pulsed during bit 4 of a byte -> all outputs at reset values in the same cycle, no m_axis beat, next triggered transaction correct.
